// File: rtl/ahb_reg_slice.sv
// ahb_reg_slice: full AHB timing-break slice between one upstream manager
// segment and one downstream subordinate. The address, write-data and response
// paths are all registered, with a single transfer outstanding at a time.
// Bursts are flattened into SINGLE/NONSEQ beats. A two-cycle ERROR from the
// subordinate is replayed upstream as a two-cycle ERROR.
// Optional build macro AHB_REG_SLICE_TIMEOUT_EN adds a watchdog. The watchdog
// errors out a hung downstream transfer and then drains the late response.
//
// Upstream accept handshake: the slice offers ready on hreadyout_o. A transfer
// is taken at a rising edge only when hsel_i, htrans_i[1] (NONSEQ/SEQ),
// hready_i and hreadyout_o are all high in that cycle. Nothing else is ever
// accepted, and the address-phase fields are sampled only at that edge.
module ahb_reg_slice #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int HBURST_WIDTH    = 3,
    parameter int HPROT_WIDTH     = 4,
    parameter int HMASTER_WIDTH   = 1,
    parameter int USER_REQ_WIDTH  = 1,
    parameter int USER_DATA_WIDTH = 1,
    parameter int USER_RESP_WIDTH = 1,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                       hclk_i,
    input  logic                       hrst_ni,
    // upstream address phase
    input  logic                       hsel_i,
    input  logic [1:0]                 htrans_i,
    input  logic [ADDR_WIDTH-1:0]      haddr_i,
    input  logic [HBURST_WIDTH-1:0]    hburst_i,
    input  logic                       hmastlock_i,
    input  logic [HPROT_WIDTH-1:0]     hprot_i,
    input  logic [2:0]                 hsize_i,
    input  logic                       hnonsec_i,
    input  logic                       hexcl_i,
    input  logic [HMASTER_WIDTH-1:0]   hmaster_i,
    input  logic                       hwrite_i,
    input  logic [DATA_WIDTH/8-1:0]    hwstrb_i,
    input  logic [USER_REQ_WIDTH-1:0]  hauser_i,
    input  logic                       hready_i,
    // upstream write data
    input  logic [DATA_WIDTH-1:0]      hwdata_i,
    input  logic [USER_DATA_WIDTH-1:0] hwuser_i,
    // upstream response
    output logic [DATA_WIDTH-1:0]      hrdata_o,
    output logic [USER_DATA_WIDTH-1:0] hruser_o,
    output logic [USER_RESP_WIDTH-1:0] hbuser_o,
    output logic                       hreadyout_o,
    output logic                       hresp_o,
    output logic                       hexokay_o,
    // downstream address phase
    output logic                       hsel_o,
    output logic [1:0]                 htrans_o,
    output logic [ADDR_WIDTH-1:0]      haddr_o,
    output logic [HBURST_WIDTH-1:0]    hburst_o,
    output logic                       hmastlock_o,
    output logic [HPROT_WIDTH-1:0]     hprot_o,
    output logic [2:0]                 hsize_o,
    output logic                       hnonsec_o,
    output logic                       hexcl_o,
    output logic [HMASTER_WIDTH-1:0]   hmaster_o,
    output logic                       hwrite_o,
    output logic [DATA_WIDTH/8-1:0]    hwstrb_o,
    output logic [USER_REQ_WIDTH-1:0]  hauser_o,
    // downstream write data
    output logic [DATA_WIDTH-1:0]      hwdata_o,
    output logic [USER_DATA_WIDTH-1:0] hwuser_o,
    // downstream response
    input  logic [DATA_WIDTH-1:0]      hrdata_i,
    input  logic [USER_DATA_WIDTH-1:0] hruser_i,
    input  logic [USER_RESP_WIDTH-1:0] hbuser_i,
    input  logic                       hreadyout_i,
    input  logic                       hresp_i,
    input  logic                       hexokay_i,
    // FSM state, for observation only
    output logic [2:0]                 dbg_state_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_RESP  = 3'd3,
        S_ERR1  = 3'd4,
        S_ERR2  = 3'd5,
        S_DRAIN = 3'd6
    } state_e;

    state_e                     r_state;
    logic                       r_hreadyout;
    logic                       r_hresp;
    logic                       r_hexokay;
    logic [DATA_WIDTH-1:0]      r_hrdata;
    logic [USER_DATA_WIDTH-1:0] r_hruser;
    logic [USER_RESP_WIDTH-1:0] r_hbuser;
    logic                       r_hsel;
    logic [1:0]                 r_htrans;
    logic [ADDR_WIDTH-1:0]      r_haddr;
    logic                       r_hmastlock;
    logic [HPROT_WIDTH-1:0]     r_hprot;
    logic [2:0]                 r_hsize;
    logic                       r_hnonsec;
    logic                       r_hexcl;
    logic [HMASTER_WIDTH-1:0]   r_hmaster;
    logic                       r_hwrite;
    logic [STRB_WIDTH-1:0]      r_hwstrb;
    logic [USER_REQ_WIDTH-1:0]  r_hauser;
    logic [DATA_WIDTH-1:0]      r_hwdata;
    logic [USER_DATA_WIDTH-1:0] r_hwuser;

    logic w_accept;
    logic w_unused;

`ifdef AHB_REG_SLICE_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);

    logic [TCNT_W-1:0] r_tcnt;
    logic              r_pend;   // transfer accepted while draining, not yet issued
    logic              r_timed;  // current error sequence came from the watchdog
    logic              w_timeout;

    // The last stalled cycle before the limit is reached fires the watchdog.
    assign w_timeout = !hreadyout_i && (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
`endif

    assign w_accept = hsel_i & htrans_i[1] & hready_i & r_hreadyout;

    // Burst type and the SEQ/NONSEQ distinction are dropped: every beat goes
    // downstream as an independent SINGLE NONSEQ transfer.
    assign w_unused = ^{hburst_i, htrans_i[0]};

    // Capture the upstream address-phase fields at every accepted transfer.
    always_ff @(posedge hclk_i or negedge hrst_ni) begin
        if (!hrst_ni) begin
            r_haddr     <= '0;
            r_hmastlock <= 1'b0;
            r_hprot     <= '0;
            r_hsize     <= '0;
            r_hnonsec   <= 1'b0;
            r_hexcl     <= 1'b0;
            r_hmaster   <= '0;
            r_hwrite    <= 1'b0;
            r_hwstrb    <= '0;
            r_hauser    <= '0;
        end else if (w_accept) begin
            r_haddr     <= haddr_i;
            r_hmastlock <= hmastlock_i;
            r_hprot     <= hprot_i;
            r_hsize     <= hsize_i;
            r_hnonsec   <= hnonsec_i;
            r_hexcl     <= hexcl_i;
            r_hmaster   <= hmaster_i;
            r_hwrite    <= hwrite_i;
            r_hwstrb    <= hwstrb_i;
            r_hauser    <= hauser_i;
        end
    end

    // Transfer FSM with registered upstream response and downstream control.
    always_ff @(posedge hclk_i or negedge hrst_ni) begin
        if (!hrst_ni) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hexokay   <= 1'b0;
            r_hrdata    <= '0;
            r_hruser    <= '0;
            r_hbuser    <= '0;
            r_hsel      <= 1'b0;
            r_htrans    <= HTRANS_IDLE;
            r_hwdata    <= '0;
            r_hwuser    <= '0;
`ifdef AHB_REG_SLICE_TIMEOUT_EN
            r_tcnt      <= '0;
            r_pend      <= 1'b0;
            r_timed     <= 1'b0;
`endif
        end else begin
            // The downstream address phase is active only while in ADDR.
            r_hsel   <= 1'b0;
            r_htrans <= HTRANS_IDLE;
`ifdef AHB_REG_SLICE_TIMEOUT_EN
            r_tcnt   <= '0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_ADDR;
                        r_hsel      <= 1'b1;
                        r_htrans    <= HTRANS_NONSEQ;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b0;
                    end
                end
                S_ADDR: begin
                    // Upstream holds write data while hreadyout_o is low.
                    r_hwdata <= hwdata_i;
                    r_hwuser <= hwuser_i;
                    if (hreadyout_i) begin
                        r_state <= S_DATA;
                    end else begin
`ifdef AHB_REG_SLICE_TIMEOUT_EN
                        if (w_timeout) begin
                            r_state   <= S_ERR1;
                            r_hresp   <= 1'b1;
                            r_hexokay <= 1'b0;
                            r_timed   <= 1'b1;
                        end else begin
                            r_hsel   <= 1'b1;
                            r_htrans <= HTRANS_NONSEQ;
                            r_tcnt   <= r_tcnt + 1'b1;
                        end
`else
                        r_hsel   <= 1'b1;
                        r_htrans <= HTRANS_NONSEQ;
`endif
                    end
                end
                S_DATA: begin
                    if (hreadyout_i) begin
                        if (hresp_i) begin
                            r_state   <= S_ERR1;
                            r_hresp   <= 1'b1;
                            r_hexokay <= 1'b0;
                        end else begin
                            r_state     <= S_RESP;
                            r_hreadyout <= 1'b1;
                            r_hresp     <= 1'b0;
                            r_hrdata    <= hrdata_i;
                            r_hexokay   <= hexokay_i;
                            r_hruser    <= hruser_i;
                            r_hbuser    <= hbuser_i;
                        end
                    end
`ifdef AHB_REG_SLICE_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state   <= S_ERR1;
                        r_hresp   <= 1'b1;
                        r_hexokay <= 1'b0;
                        r_timed   <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    r_hresp <= 1'b0;
                    if (w_accept) begin
                        r_state     <= S_ADDR;
                        r_hsel      <= 1'b1;
                        r_htrans    <= HTRANS_NONSEQ;
                        r_hreadyout <= 1'b0;
                    end else begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                S_ERR2: begin
                    r_hresp <= 1'b0;
`ifdef AHB_REG_SLICE_TIMEOUT_EN
                    if (r_timed) begin
                        // The hung transfer may still answer; absorb it first.
                        r_state <= S_DRAIN;
                        r_timed <= 1'b0;
                        if (w_accept) begin
                            r_pend      <= 1'b1;
                            r_hreadyout <= 1'b0;
                        end else begin
                            r_hreadyout <= 1'b1;
                        end
                    end else
`endif
                    if (w_accept) begin
                        r_state     <= S_ADDR;
                        r_hsel      <= 1'b1;
                        r_htrans    <= HTRANS_NONSEQ;
                        r_hreadyout <= 1'b0;
                    end else begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                    end
                end
`ifdef AHB_REG_SLICE_TIMEOUT_EN
                S_DRAIN: begin
                    r_hresp <= 1'b0;
                    if (hreadyout_i) begin
                        r_pend <= 1'b0;
                        if (r_pend || w_accept) begin
                            r_state     <= S_ADDR;
                            r_hsel      <= 1'b1;
                            r_htrans    <= HTRANS_NONSEQ;
                            r_hreadyout <= 1'b0;
                        end else begin
                            r_state     <= S_IDLE;
                            r_hreadyout <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_pend      <= 1'b1;
                        r_hreadyout <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state     <= S_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                end
            endcase
        end
    end

    assign hrdata_o    = r_hrdata;
    assign hruser_o    = r_hruser;
    assign hbuser_o    = r_hbuser;
    assign hreadyout_o = r_hreadyout;
    assign hresp_o     = r_hresp;
    assign hexokay_o   = r_hexokay;

    assign hsel_o      = r_hsel;
    assign htrans_o    = r_htrans;
    assign haddr_o     = r_haddr;
    assign hburst_o    = '0;
    assign hmastlock_o = r_hmastlock;
    assign hprot_o     = r_hprot;
    assign hsize_o     = r_hsize;
    assign hnonsec_o   = r_hnonsec;
    assign hexcl_o     = r_hexcl;
    assign hmaster_o   = r_hmaster;
    assign hwrite_o    = r_hwrite;
    assign hwstrb_o    = r_hwstrb;
    assign hauser_o    = r_hauser;

    assign hwdata_o    = r_hwdata;
    assign hwuser_o    = r_hwuser;

    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ahb_reg_slice.sv
// Directed bench for ahb_reg_slice. It drives upstream transfers and plays the
// downstream subordinate cycle by cycle. Expected addresses and data are queued
// as stimulus is driven, then popped where the slice produces them.
module tb_ahb_reg_slice;

    logic        hclk_i = 1'b0;
    logic        hrst_ni;

    logic        hsel_i;
    logic [1:0]  htrans_i;
    logic [31:0] haddr_i;
    logic [2:0]  hburst_i;
    logic        hmastlock_i;
    logic [3:0]  hprot_i;
    logic [2:0]  hsize_i;
    logic        hnonsec_i;
    logic        hexcl_i;
    logic [0:0]  hmaster_i;
    logic        hwrite_i;
    logic [3:0]  hwstrb_i;
    logic [0:0]  hauser_i;
    logic        hready_i;
    logic [31:0] hwdata_i;
    logic [0:0]  hwuser_i;
    logic [31:0] hrdata_o;
    logic [0:0]  hruser_o;
    logic [0:0]  hbuser_o;
    logic        hreadyout_o;
    logic        hresp_o;
    logic        hexokay_o;
    logic        hsel_o;
    logic [1:0]  htrans_o;
    logic [31:0] haddr_o;
    logic [2:0]  hburst_o;
    logic        hmastlock_o;
    logic [3:0]  hprot_o;
    logic [2:0]  hsize_o;
    logic        hnonsec_o;
    logic        hexcl_o;
    logic [0:0]  hmaster_o;
    logic        hwrite_o;
    logic [3:0]  hwstrb_o;
    logic [0:0]  hauser_o;
    logic [31:0] hwdata_o;
    logic [0:0]  hwuser_o;
    logic [31:0] hrdata_i;
    logic [0:0]  hruser_i;
    logic [0:0]  hbuser_i;
    logic        hreadyout_i;
    logic        hresp_i;
    logic        hexokay_i;
    logic [2:0]  dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] addr_q[$];
    logic [31:0] wdata_q[$];
    logic [31:0] rdata_q[$];

    ahb_reg_slice #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .HBURST_WIDTH(3), .HPROT_WIDTH(4),
        .HMASTER_WIDTH(1), .USER_REQ_WIDTH(1), .USER_DATA_WIDTH(1),
        .USER_RESP_WIDTH(1), .TIMEOUT_CYCLES(8)
    ) dut (
        .hclk_i(hclk_i), .hrst_ni(hrst_ni),
        .hsel_i(hsel_i), .htrans_i(htrans_i), .haddr_i(haddr_i), .hburst_i(hburst_i),
        .hmastlock_i(hmastlock_i), .hprot_i(hprot_i), .hsize_i(hsize_i),
        .hnonsec_i(hnonsec_i), .hexcl_i(hexcl_i), .hmaster_i(hmaster_i),
        .hwrite_i(hwrite_i), .hwstrb_i(hwstrb_i), .hauser_i(hauser_i),
        .hready_i(hready_i), .hwdata_i(hwdata_i), .hwuser_i(hwuser_i),
        .hrdata_o(hrdata_o), .hruser_o(hruser_o), .hbuser_o(hbuser_o),
        .hreadyout_o(hreadyout_o), .hresp_o(hresp_o), .hexokay_o(hexokay_o),
        .hsel_o(hsel_o), .htrans_o(htrans_o), .haddr_o(haddr_o), .hburst_o(hburst_o),
        .hmastlock_o(hmastlock_o), .hprot_o(hprot_o), .hsize_o(hsize_o),
        .hnonsec_o(hnonsec_o), .hexcl_o(hexcl_o), .hmaster_o(hmaster_o),
        .hwrite_o(hwrite_o), .hwstrb_o(hwstrb_o), .hauser_o(hauser_o),
        .hwdata_o(hwdata_o), .hwuser_o(hwuser_o),
        .hrdata_i(hrdata_i), .hruser_i(hruser_i), .hbuser_i(hbuser_i),
        .hreadyout_i(hreadyout_i), .hresp_i(hresp_i), .hexokay_i(hexokay_i),
        .dbg_state_o(dbg_state_o)
    );

    // clock
    always #5 hclk_i = ~hclk_i;

    // advance to just after the next rising edge
    task automatic step();
        @(posedge hclk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic idle();
        hsel_i   = 1'b0;
        htrans_i = 2'b00;
        hburst_i = 3'b000;
        step();
    endtask

    // One upstream transfer, driven in a cycle where hreadyout_o is high.
    // Returns in the final response cycle (RESP or ERR2) without stepping on,
    // so the caller may present the next address phase back to back.
    task automatic xfer(input logic [1:0] tr, input logic [2:0] burst, input logic [31:0] addr,
                        input logic wr, input logic [31:0] wdata, input int nwait,
                        input bit err, input logic [31:0] rdata);
        logic [31:0] e;
        hsel_i   = 1'b1;
        htrans_i = tr;
        hburst_i = burst;
        haddr_i  = addr;
        hwrite_i = wr;
        hready_i = 1'b1;
        addr_q.push_back(addr);
        if (wr) wdata_q.push_back(wdata);
        else if (!err) rdata_q.push_back(rdata);
        step();
        // downstream address phase
        e = addr_q.pop_front();
        chk("addr_htrans", htrans_o, 32'd2);
        chk("addr_hsel", hsel_o, 32'd1);
        chk("addr_hburst", hburst_o, 32'd0);
        chk("addr_haddr", haddr_o, e);
        chk("addr_hwrite", hwrite_o, wr);
        chk("addr_rdy", hreadyout_o, 32'd0);
        hsel_i      = 1'b0;
        htrans_i    = 2'b00;
        hburst_i    = 3'b000;
        hwdata_i    = wdata;
        hreadyout_i = 1'b1;
        hresp_i     = 1'b0;
        step();
        // downstream data phase
        chk("data_htrans", htrans_o, 32'd0);
        chk("data_hsel", hsel_o, 32'd0);
        chk("data_rdy", hreadyout_o, 32'd0);
        if (wr) begin
            e = wdata_q.pop_front();
            chk("data_hwdata", hwdata_o, e);
        end
        for (int i = 0; i < nwait; i++) begin
            hreadyout_i = 1'b0;
            step();
            chk("wait_rdy", hreadyout_o, 32'd0);
        end
        if (err) begin
            hreadyout_i = 1'b0;
            hresp_i     = 1'b1;
            step();
            chk("err0_rdy", hreadyout_o, 32'd0);
            chk("err0_resp", hresp_o, 32'd0);
            hreadyout_i = 1'b1;
            hresp_i     = 1'b1;
            step();
            chk("err1_rdy", hreadyout_o, 32'd0);
            chk("err1_resp", hresp_o, 32'd1);
            hresp_i = 1'b0;
            step();
            chk("err2_rdy", hreadyout_o, 32'd1);
            chk("err2_resp", hresp_o, 32'd1);
            chk("err2_exokay", hexokay_o, 32'd0);
        end else begin
            hreadyout_i = 1'b1;
            hrdata_i    = rdata;
            hexokay_i   = 1'b1;
            step();
            // downstream moves on; the captured response must not follow it
            hrdata_i  = ~rdata;
            hexokay_i = 1'b0;
            chk("resp_rdy", hreadyout_o, 32'd1);
            chk("resp_resp", hresp_o, 32'd0);
            if (!wr) begin
                e = rdata_q.pop_front();
                chk("resp_hrdata", hrdata_o, e);
                chk("resp_exokay", hexokay_o, 32'd1);
            end
        end
    endtask

    initial begin
        hrst_ni = 1'b0;
        hsel_i = 1'b0; htrans_i = 2'b00; haddr_i = '0; hburst_i = '0;
        hmastlock_i = 1'b0; hprot_i = 4'h3; hsize_i = 3'b010; hnonsec_i = 1'b0;
        hexcl_i = 1'b0; hmaster_i = '0; hwrite_i = 1'b0; hwstrb_i = 4'hF;
        hauser_i = '0; hready_i = 1'b1; hwdata_i = '0; hwuser_i = '0;
        hrdata_i = '0; hruser_i = '0; hbuser_i = '0;
        hreadyout_i = 1'b1; hresp_i = 1'b0; hexokay_i = 1'b0;
        step();
        step();

        // reset state
        chk("rst_rdy", hreadyout_o, 32'd1);
        chk("rst_htrans", htrans_o, 32'd0);
        chk("rst_hsel", hsel_o, 32'd0);
        chk("rst_hresp", hresp_o, 32'd0);
        chk("rst_hrdata", hrdata_o, 32'd0);
        chk("rst_haddr", haddr_o, 32'd0);
        chk("rst_hwdata", hwdata_o, 32'd0);
        chk("rst_state", dbg_state_o, 32'd0);
        hrst_ni = 1'b1;
        step();

        // write, zero-wait downstream
        xfer(2'b10, 3'b000, 32'h100, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'h0);
        idle();

        // read, two downstream wait states
        xfer(2'b10, 3'b000, 32'h200, 1'b0, 32'h0, 2, 1'b0, 32'h12345678);
        idle();
        chk("hold_hrdata", hrdata_o, 32'h12345678);
        chk("idle_rdy", hreadyout_o, 32'd1);

        // INCR4 burst flattened into four NONSEQ singles, accepted from RESP
        xfer(2'b10, 3'b001, 32'h1000, 1'b1, 32'hA0A0_0000 | 32'($urandom_range(0, 255)), 0, 1'b0, 32'h0);
        xfer(2'b11, 3'b001, 32'h1004, 1'b1, 32'hA0A0_0100, 1, 1'b0, 32'h0);
        xfer(2'b11, 3'b001, 32'h1008, 1'b1, 32'hA0A0_0200, 0, 1'b0, 32'h0);
        xfer(2'b11, 3'b001, 32'h100C, 1'b1, 32'hA0A0_0300, 2, 1'b0, 32'h0);
        idle();

        // two-cycle downstream ERROR, then NONSEQ accepted in ERR2
        xfer(2'b10, 3'b000, 32'h500, 1'b0, 32'h0, 1, 1'b1, 32'h0);
        xfer(2'b10, 3'b000, 32'h600, 1'b0, 32'h0, 0, 1'b0, 32'hCAFEF00D);
        idle();

        // no accept without hready_i, on BUSY, or without hsel_i
        hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 32'h700; hready_i = 1'b0;
        step();
        chk("nohready_htrans", htrans_o, 32'd0);
        chk("nohready_rdy", hreadyout_o, 32'd1);
        hready_i = 1'b1; htrans_i = 2'b01;
        step();
        chk("busy_htrans", htrans_o, 32'd0);
        hsel_i = 1'b0; htrans_i = 2'b10;
        step();
        chk("nosel_hsel", hsel_o, 32'd0);
        idle();

        // asynchronous reset in the middle of ADDR drops the transfer
        hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 32'h800; hwrite_i = 1'b0;
        step();
        chk("prerst_htrans", htrans_o, 32'd2);
        hsel_i = 1'b0; htrans_i = 2'b00;
        hrst_ni = 1'b0;
        #1;
        chk("midrst_rdy", hreadyout_o, 32'd1);
        step();
        chk("midrst_htrans", htrans_o, 32'd0);
        chk("midrst_hsel", hsel_o, 32'd0);
        chk("midrst_hrdata", hrdata_o, 32'd0);
        hrst_ni = 1'b1;
        step();

`ifdef AHB_REG_SLICE_TIMEOUT_EN
        // watchdog: downstream stuck low for 8 cycles, next transfer held
        hreadyout_i = 1'b0;
        hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 32'h300; hwrite_i = 1'b0;
        addr_q.push_back(32'h300);
        step();
        chk("to_addr_haddr", haddr_o, addr_q.pop_front());
        hsel_i = 1'b0; htrans_i = 2'b00;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to_stall_rdy", hreadyout_o, 32'd0);
            chk("to_stall_htrans", htrans_o, 32'd2);
        end
        step();
        chk("to_err1_rdy", hreadyout_o, 32'd0);
        chk("to_err1_resp", hresp_o, 32'd1);
        step();
        chk("to_err2_rdy", hreadyout_o, 32'd1);
        chk("to_err2_resp", hresp_o, 32'd1);
        hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 32'h400; hwrite_i = 1'b1;
        addr_q.push_back(32'h400);
        wdata_q.push_back(32'h55AA55AA);
        step();
        chk("drain_rdy", hreadyout_o, 32'd0);
        chk("drain_htrans", htrans_o, 32'd0);
        hsel_i = 1'b0; htrans_i = 2'b00; hwdata_i = 32'h55AA55AA;
        step();
        chk("drain_hold_htrans", htrans_o, 32'd0);
        hreadyout_i = 1'b1;
        step();
        chk("pend_htrans", htrans_o, 32'd2);
        chk("pend_haddr", haddr_o, addr_q.pop_front());
        step();
        chk("pend_hwdata", hwdata_o, wdata_q.pop_front());
        step();
        chk("pend_resp_rdy", hreadyout_o, 32'd1);
        idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
